crossing_detect_sequencer: RTL and testbench
============================================

Name: crossing_detect_sequencer

Overview:
Frame-level controller that sits between the camera/convolution pixel stream and the zebra crossing detector. It aligns the detector to frame boundaries by gating the pixel valid and owning the detector reset. It waits for each per-frame result, applies N-frame on/off hysteresis to produce a stable crossing flag, and recovers the detector from aborted frames or missing results.

Parameters:
IMG_WIDTH, 640, pixels per row (must match detector)
IMG_HEIGHT, 480, rows per frame (must match detector)
HYST_ON, 3, consecutive qualifying frames required to assert crossing_state
HYST_OFF, 2, consecutive non-qualifying frames required to clear crossing_state
TIMEOUT_CYCLES, 1024, max cycles in WAIT_RESULT before recovery

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  level; run detection while high
conf_min  in  16  minimum detector confidence for a frame to qualify
pix_valid_in  in  1  upstream pixel valid (transfer already qualified)
sof  in  1  start-of-frame; meaningful only with pix_valid_in, marks first pixel
det_pixel_valid  out  1  gated pixel valid to detector (combinational)
det_rst_n  out  1  registered detector reset, active-low
det_valid  in  1  detector detection_valid pulse
det_crossing  in  1  detector crossing_detected
det_confidence  in  16  detector confidence
crossing_state  out  1  debounced crossing flag
crossing_event  out  1  one-cycle pulse on 0->1 of crossing_state
frame_count  out  16  results accepted; wraps at 2^16
timeout_err  out  1  sticky; set on result timeout
abort_err  out  1  sticky; set on premature sof
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: det_rst_n=0, det_pixel_valid=0, crossing_state=0, crossing_event=0, frame_count=0, timeout_err=0, abort_err=0, busy=0, state=IDLE, hit/miss/pixel/timeout counters=0.
- FSM states: IDLE, WAIT_SOF, STREAM, WAIT_RESULT, RECOVER.
- IDLE: det_rst_n=0, gate closed, hysteresis counters held. enable=1 -> WAIT_SOF.
- WAIT_SOF: det_rst_n=1. pix_valid_in&&sof -> forward that pixel (det_pixel_valid=1 in the same cycle), pixel count=1, -> STREAM. Pixels without sof are dropped. enable=0 -> IDLE.
- STREAM: det_pixel_valid=pix_valid_in&&!sof. Count forwarded pixels. On forwarding pixel IMG_WIDTH*IMG_HEIGHT -> WAIT_RESULT, timeout counter cleared. enable dropping mid-frame does not abort; the frame completes.
- Premature sof in STREAM (pix_valid_in&&sof): pixel not forwarded, abort_err<=1, -> RECOVER. That frame is lost; resync occurs on the next sof.
- WAIT_RESULT: gate closed. det_valid -> evaluate frame; then enable ? WAIT_SOF : IDLE. Otherwise timeout counter++. Reaching TIMEOUT_CYCLES-1 without det_valid -> timeout_err<=1, -> RECOVER; the frame is not evaluated and frame_count is unchanged.
- RECOVER: det_rst_n=0 for exactly one cycle, counters cleared, -> WAIT_SOF (or IDLE if enable=0). Hysteresis state is preserved.
- det_valid outside WAIT_RESULT is ignored.
- Frame evaluation, registered, effective the cycle after det_valid:
  - frame_count++.
  - Qualifying frame (det_crossing && det_confidence>=conf_min): hit_cnt=min(hit_cnt+1,HYST_ON), miss_cnt=0.
  - Non-qualifying frame: miss_cnt=min(miss_cnt+1,HYST_OFF), hit_cnt=0.
  - crossing_state 0->1 when the updated hit_cnt==HYST_ON; crossing_event pulses in the same cycle.
  - crossing_state 1->0 when the updated miss_cnt==HYST_OFF; no event pulse on clear.
- Pixel counter width is $clog2(IMG_WIDTH*IMG_HEIGHT+1). Timeout counter width is $clog2(TIMEOUT_CYCLES).
- Sticky errors clear only on rst_n.
- Asynchronous reset mid-frame returns to IDLE with the detector held in reset.

Decomposition:
- Package crossing_seq_pkg: state enum (IDLE, WAIT_SOF, STREAM, WAIT_RESULT, RECOVER), confidence width constant CONF_W=16.
- Sub-module frame_hysteresis: hit/miss counters, crossing_state, crossing_event; inputs eval_strobe and qualify.
- FSM and pixel/timeout counters stay in the top module.

Test Plan:
All scenarios use IMG 8x4 (32 px), HYST_ON=3, HYST_OFF=2, TIMEOUT=16, conf_min=100.
- Startup: rst released, enable=1, 5 px without sof then sof + 32 px -> first 5 dropped; exactly 32 det_pixel_valid pulses; state WAIT_RESULT after the 32nd; det_rst_n=1 from WAIT_SOF on.
- Hysteresis on: 3 frames with det_valid, det_crossing=1, conf=120 -> crossing_state rises and crossing_event pulses once, the cycle after the 3rd det_valid; frame_count=3.
- Confidence gate and off: frames (1,conf=99),(1,200),(0,x),(0,x) from state=1 -> the first counts as a miss, the second resets miss, the fourth clears crossing_state; no event pulse.
- Premature sof: sof at pixel 20 of a frame -> abort_err=1, det_rst_n low exactly 1 cycle, sof pixel not forwarded, next full frame processed normally.
- Timeout: complete a frame, withhold det_valid -> after 16 cycles timeout_err=1, one-cycle det_rst_n pulse, frame_count unchanged, late det_valid ignored.
- Enable drop: deassert enable at pixel 10 -> frame completes, result evaluated, then IDLE with det_rst_n=0, busy=0.

Source files
------------

// File: rtl/crossing_seq_pkg.sv
// Shared types for the crossing detector frame sequencer.
package crossing_seq_pkg;

    localparam int CONF_W = 16;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_SOF    = 3'd1,
        STREAM      = 3'd2,
        WAIT_RESULT = 3'd3,
        RECOVER     = 3'd4
    } seq_state_e;

    // A frame counts toward the crossing flag only when confident enough.
    function automatic logic frame_qualifies(
        input logic              crossing,
        input logic [CONF_W-1:0] conf,
        input logic [CONF_W-1:0] conf_min
    );
        return crossing && (conf >= conf_min);
    endfunction

endpackage

// File: rtl/frame_hysteresis.sv
// N-frame on/off debounce of per-frame detector verdicts into a stable crossing flag.
module frame_hysteresis #(
    parameter int HYST_ON  = 3,
    parameter int HYST_OFF = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic eval_strobe,
    input  logic qualify,
    output logic crossing_state,
    output logic crossing_event
);

    localparam int HIT_W  = $clog2(HYST_ON + 1);
    localparam int MISS_W = $clog2(HYST_OFF + 1);
    localparam logic [HIT_W-1:0]  HIT_MAX  = HIT_W'(HYST_ON);
    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(HYST_OFF);

    logic [HIT_W-1:0]  hit_cnt_r, hit_cnt_s;
    logic [MISS_W-1:0] miss_cnt_r, miss_cnt_s;
    logic              state_r, state_s;
    logic              event_r, event_s;

    // Saturating run counters and flag update for one evaluated frame.
    always_comb begin
        hit_cnt_s  = hit_cnt_r;
        miss_cnt_s = miss_cnt_r;
        state_s    = state_r;
        event_s    = 1'b0;
        if (eval_strobe) begin
            if (qualify) begin
                hit_cnt_s  = (hit_cnt_r == HIT_MAX) ? HIT_MAX : hit_cnt_r + HIT_W'(1);
                miss_cnt_s = {MISS_W{1'b0}};
            end else begin
                miss_cnt_s = (miss_cnt_r == MISS_MAX) ? MISS_MAX : miss_cnt_r + MISS_W'(1);
                hit_cnt_s  = {HIT_W{1'b0}};
            end
            if ((hit_cnt_s == HIT_MAX) && !state_r) begin
                state_s = 1'b1;
                event_s = 1'b1;
            end else if (miss_cnt_s == MISS_MAX) begin
                state_s = 1'b0;
            end else begin
                state_s = state_r;
            end
        end else begin
            event_s = 1'b0;
        end
    end

    // Hysteresis state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_r  <= {HIT_W{1'b0}};
            miss_cnt_r <= {MISS_W{1'b0}};
            state_r    <= 1'b0;
            event_r    <= 1'b0;
        end else begin
            hit_cnt_r  <= hit_cnt_s;
            miss_cnt_r <= miss_cnt_s;
            state_r    <= state_s;
            event_r    <= event_s;
        end
    end

    assign crossing_state = state_r;
    assign crossing_event = event_r;

endmodule

// File: rtl/crossing_detect_sequencer.sv
// Frame-aligns the zebra crossing detector, collects per-frame results and
// recovers the detector after aborted frames or missing results.
module crossing_detect_sequencer
    import crossing_seq_pkg::*;
#(
    parameter int IMG_WIDTH      = 640,
    parameter int IMG_HEIGHT     = 480,
    parameter int HYST_ON        = 3,
    parameter int HYST_OFF       = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [CONF_W-1:0] conf_min,
    input  logic              pix_valid_in,
    input  logic              sof,
    output logic              det_pixel_valid,
    output logic              det_rst_n,
    input  logic              det_valid,
    input  logic              det_crossing,
    input  logic [CONF_W-1:0] det_confidence,
    output logic              crossing_state,
    output logic              crossing_event,
    output logic [15:0]       frame_count,
    output logic              timeout_err,
    output logic              abort_err,
    output logic              busy
);

    localparam int PIX_TOTAL = IMG_WIDTH * IMG_HEIGHT;
    localparam int PIX_W     = $clog2(PIX_TOTAL + 1);
    localparam int TMO_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_TOTAL);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    seq_state_e        state_r, state_s;
    logic [PIX_W-1:0]  pix_cnt_r, pix_cnt_s, pix_inc_s;
    logic [TMO_W-1:0]  tmo_cnt_r, tmo_cnt_s;
    logic              fwd_s, eval_s, abort_s, timeout_s, qualify_s;
    logic              det_rst_n_r, busy_r, timeout_err_r, abort_err_r;
    logic [15:0]       frame_cnt_r;

    // Next-state, pixel gating and counter updates.
    always_comb begin
        state_s   = state_r;
        pix_cnt_s = pix_cnt_r;
        tmo_cnt_s = tmo_cnt_r;
        fwd_s     = 1'b0;
        eval_s    = 1'b0;
        abort_s   = 1'b0;
        timeout_s = 1'b0;
        pix_inc_s = pix_cnt_r + PIX_W'(1);
        case (state_r)
            IDLE: begin
                pix_cnt_s = {PIX_W{1'b0}};
                tmo_cnt_s = {TMO_W{1'b0}};
                if (enable) begin
                    state_s = WAIT_SOF;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_SOF: begin
                if (pix_valid_in && sof) begin
                    fwd_s     = 1'b1;
                    pix_cnt_s = PIX_W'(1);
                    state_s   = STREAM;
                end else if (!enable) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_SOF;
                end
            end
            STREAM: begin
                // A second sof mid-frame means upstream lost sync; drop the frame.
                if (pix_valid_in && sof) begin
                    abort_s = 1'b1;
                    state_s = RECOVER;
                end else if (pix_valid_in) begin
                    fwd_s     = 1'b1;
                    pix_cnt_s = pix_inc_s;
                    if (pix_inc_s == PIX_LAST) begin
                        tmo_cnt_s = {TMO_W{1'b0}};
                        state_s   = WAIT_RESULT;
                    end else begin
                        state_s = STREAM;
                    end
                end else begin
                    state_s = STREAM;
                end
            end
            WAIT_RESULT: begin
                if (det_valid) begin
                    eval_s  = 1'b1;
                    state_s = enable ? WAIT_SOF : IDLE;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    timeout_s = 1'b1;
                    state_s   = RECOVER;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
                end
            end
            RECOVER: begin
                pix_cnt_s = {PIX_W{1'b0}};
                tmo_cnt_s = {TMO_W{1'b0}};
                state_s   = enable ? WAIT_SOF : IDLE;
            end
            default: begin
                pix_cnt_s = {PIX_W{1'b0}};
                tmo_cnt_s = {TMO_W{1'b0}};
                state_s   = IDLE;
            end
        endcase
    end

    assign qualify_s = frame_qualifies(det_crossing, det_confidence, conf_min);

    // State, counters, detector reset and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            pix_cnt_r     <= {PIX_W{1'b0}};
            tmo_cnt_r     <= {TMO_W{1'b0}};
            det_rst_n_r   <= 1'b0;
            busy_r        <= 1'b0;
            frame_cnt_r   <= 16'd0;
            timeout_err_r <= 1'b0;
            abort_err_r   <= 1'b0;
        end else begin
            state_r       <= state_s;
            pix_cnt_r     <= pix_cnt_s;
            tmo_cnt_r     <= tmo_cnt_s;
            // Detector runs only in the streaming states; registered from next state.
            det_rst_n_r   <= (state_s == WAIT_SOF) || (state_s == STREAM) ||
                             (state_s == WAIT_RESULT);
            busy_r        <= (state_s != IDLE);
            frame_cnt_r   <= eval_s ? frame_cnt_r + 16'd1 : frame_cnt_r;
            timeout_err_r <= timeout_err_r | timeout_s;
            abort_err_r   <= abort_err_r | abort_s;
        end
    end

    frame_hysteresis #(
        .HYST_ON  (HYST_ON),
        .HYST_OFF (HYST_OFF)
    ) u_hyst (
        .clk            (clk),
        .rst_n          (rst_n),
        .eval_strobe    (eval_s),
        .qualify        (qualify_s),
        .crossing_state (crossing_state),
        .crossing_event (crossing_event)
    );

    assign det_pixel_valid = fwd_s;
    assign det_rst_n       = det_rst_n_r;
    assign busy            = busy_r;
    assign frame_count     = frame_cnt_r;
    assign timeout_err     = timeout_err_r;
    assign abort_err       = abort_err_r;

endmodule

// File: tb/tb_crossing_detect_sequencer.sv
// Directed plus randomized bench for crossing_detect_sequencer on an 8x4 frame.
module tb_crossing_detect_sequencer;
    import crossing_seq_pkg::*;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int NPX  = W * H;
    localparam int HON  = 3;
    localparam int HOFF = 2;
    localparam int TMO  = 16;
    localparam int CMIN = 100;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic [CONF_W-1:0] conf_min;
    logic              pix_valid_in;
    logic              sof;
    logic              det_pixel_valid;
    logic              det_rst_n;
    logic              det_valid;
    logic              det_crossing;
    logic [CONF_W-1:0] det_confidence;
    logic              crossing_state;
    logic              crossing_event;
    logic [15:0]       frame_count;
    logic              timeout_err;
    logic              abort_err;
    logic              busy;

    int n_cmp = 0;
    int n_fail = 0;
    int fwd_cnt = 0;
    int ev_cnt = 0;

    bit hist[$];
    bit exp_st = 1'b0;
    bit exp_ev = 1'b0;
    int exp_fc = 0;

    crossing_detect_sequencer #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .HYST_ON(HON), .HYST_OFF(HOFF), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .conf_min(conf_min),
        .pix_valid_in(pix_valid_in), .sof(sof), .det_pixel_valid(det_pixel_valid),
        .det_rst_n(det_rst_n), .det_valid(det_valid), .det_crossing(det_crossing),
        .det_confidence(det_confidence), .crossing_state(crossing_state),
        .crossing_event(crossing_event), .frame_count(frame_count),
        .timeout_err(timeout_err), .abort_err(abort_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (det_pixel_valid) fwd_cnt <= fwd_cnt + 1;
        if (crossing_event) ev_cnt <= ev_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input bit s, input bit gap);
        pix_valid_in = 1'b1;
        sof = s;
        step();
        pix_valid_in = 1'b0;
        sof = 1'b0;
        if (gap) repeat ($urandom_range(0, 1)) step();
    endtask

    task automatic send_frame();
        pix(1'b1, 1'b1);
        for (int i = 1; i < NPX; i++) pix(1'b0, i != NPX - 1);
    endtask

    // Reference: flag is set when the last HON evaluated frames all qualified,
    // cleared when the last HOFF all failed, otherwise unchanged.
    task automatic model_eval(input bit q);
        bit all_on, all_off;
        int n;
        hist.push_back(q);
        n = hist.size();
        exp_fc++;
        exp_ev = 1'b0;
        all_on = (n >= HON);
        for (int k = 0; k < HON && all_on; k++) if (!hist[n-1-k]) all_on = 1'b0;
        all_off = (n >= HOFF);
        for (int k = 0; k < HOFF && all_off; k++) if (hist[n-1-k]) all_off = 1'b0;
        if (all_on && !exp_st) begin
            exp_st = 1'b1;
            exp_ev = 1'b1;
        end else if (all_off) begin
            exp_st = 1'b0;
        end
    endtask

    task automatic give_result(input bit cr, input int conf);
        det_valid = 1'b1;
        det_crossing = cr;
        det_confidence = CONF_W'(conf);
        step();
        det_valid = 1'b0;
        det_crossing = 1'b0;
        model_eval(cr && (conf >= CMIN));
        check("res_state", crossing_state, exp_st);
        check("res_event", crossing_event, exp_ev);
        check("res_frame_count", frame_count, exp_fc);
    endtask

    initial begin
        int base, n, ev0;
        rst_n = 1'b0; enable = 1'b0; conf_min = CONF_W'(CMIN);
        pix_valid_in = 1'b0; sof = 1'b0;
        det_valid = 1'b0; det_crossing = 1'b0; det_confidence = '0;
        #2;
        check("rst_det_rst_n", det_rst_n, 0);
        check("rst_det_pixel_valid", det_pixel_valid, 0);
        check("rst_crossing_state", crossing_state, 0);
        check("rst_crossing_event", crossing_event, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_abort_err", abort_err, 0);
        check("rst_busy", busy, 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("idle_busy", busy, 0);

        // Startup: pixels before sof are dropped, then one full frame.
        enable = 1'b1;
        step();
        check("start_det_rst_n", det_rst_n, 1);
        check("start_busy", busy, 1);
        base = fwd_cnt;
        repeat (5) pix(1'b0, 1'b1);
        check("pre_sof_dropped", fwd_cnt - base, 0);
        base = fwd_cnt;
        send_frame();
        check("frame_pixels", fwd_cnt - base, NPX);
        pix_valid_in = 1'b1;
        #1;
        check("gate_closed_wait_result", det_pixel_valid, 0);
        pix_valid_in = 1'b0;
        give_result(1'b1, 120);

        // Hysteresis rises on the third qualifying frame.
        repeat (2) begin
            send_frame();
            repeat ($urandom_range(0, 3)) step();
            give_result(1'b1, 120);
        end
        check("hyst_on_event", crossing_event, 1);
        step();
        check("event_one_cycle", crossing_event, 0);
        check("event_count_on", ev_cnt, 1);
        check("fc_after_on", frame_count, 3);

        // Confidence boundary and clear, no event on clear.
        send_frame(); give_result(1'b1, 99);
        check("conf99_is_miss", crossing_state, 1);
        send_frame(); give_result(1'b1, 200);
        send_frame(); give_result(1'b0, $urandom_range(0, 300));
        send_frame(); give_result(1'b0, $urandom_range(0, 300));
        check("hyst_off", crossing_state, 0);
        check("event_count_off", ev_cnt, 1);

        // Premature sof at pixel 20.
        base = fwd_cnt;
        pix(1'b1, 1'b1);
        for (int i = 1; i < 19; i++) pix(1'b0, 1'b1);
        pix(1'b1, 1'b0);
        check("abort_err", abort_err, 1);
        check("abort_det_rst_low", det_rst_n, 0);
        check("abort_fwd", fwd_cnt - base, 19);
        step();
        check("abort_det_rst_one_cycle", det_rst_n, 1);
        base = fwd_cnt;
        send_frame();
        check("post_abort_pixels", fwd_cnt - base, NPX);
        give_result(1'b1, 150);

        // Timeout while waiting for a result.
        send_frame();
        n = 0;
        while (timeout_err !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("timeout_cycles", n, TMO);
        check("timeout_det_rst_low", det_rst_n, 0);
        step();
        check("timeout_det_rst_one_cycle", det_rst_n, 1);
        check("timeout_fc_unchanged", frame_count, exp_fc);
        det_valid = 1'b1; det_crossing = 1'b1; det_confidence = CONF_W'(200);
        step();
        det_valid = 1'b0;
        step();
        check("late_valid_fc", frame_count, exp_fc);
        check("late_valid_state", crossing_state, exp_st);
        check("timeout_sticky", timeout_err, 1);

        // Randomized frames against the history model.
        repeat (12) begin
            send_frame();
            repeat ($urandom_range(0, 4)) step();
            give_result($urandom_range(0, 3) != 0, $urandom_range(90, 110));
        end

        // Enable drop mid-frame: frame completes, then IDLE.
        base = fwd_cnt;
        pix(1'b1, 1'b1);
        for (int i = 1; i < 9; i++) pix(1'b0, 1'b1);
        enable = 1'b0;
        for (int i = 9; i < NPX; i++) pix(1'b0, i != NPX - 1);
        check("drop_pixels", fwd_cnt - base, NPX);
        check("drop_busy_mid", busy, 1);
        give_result(1'b1, 130);
        check("drop_idle_busy", busy, 0);
        check("drop_idle_det_rst", det_rst_n, 0);
        check("abort_sticky", abort_err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
